// File: rtl/pool_window_fetch_pkg.sv
// Shared definitions for the pooling window fetcher: element width and FSM state encoding.
package pool_window_fetch_pkg;

  localparam int BRAM_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_t;

  // Element order is {bottom-right, bottom-left, top-right, top-left}; top-left is always inside.
  function automatic logic [3:0] window_enables(input logic right_ok, input logic bottom_ok);
    return {right_ok & bottom_ok, bottom_ok, right_ok, 1'b1};
  endfunction

endpackage

// File: rtl/pool_window_fetch_shift_reg.sv
// Fixed-depth delay line with synchronous flush; aligns read strobes with BRAM read data.
module shift_reg #(
  parameter int CLOCK_CYCLES = 1,
  parameter int DATA_WIDTH   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] stages [CLOCK_CYCLES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CLOCK_CYCLES; i++) stages[i] <= '0;
    end else begin
      stages[0] <= din;
      for (int i = 1; i < CLOCK_CYCLES; i++) stages[i] <= stages[i-1];
    end
  end

  assign dout = stages[CLOCK_CYCLES-1];

endmodule

// File: rtl/pool_window_fetch.sv
// Issues one 2x2 pooling window per cycle from four BRAM ports in raster order.
// Define POOL_FETCH_ODD_EDGE_EN to emit partial windows on odd trailing columns/rows.
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_ISSUE | one window of reads per cycle
// ST_DRAIN | RD_LATENCY cycles for the last reads to return
// ST_DONE  | one-cycle done pulse
module pool_window_fetch
  import pool_window_fetch_pkg::*;
#(
  parameter int BRAM_DATA_WIDTH = pool_window_fetch_pkg::BRAM_DATA_WIDTH,
  parameter int ADDR_WIDTH      = 12,
  parameter int DIM_WIDTH       = 9,
  parameter int RD_LATENCY      = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [ADDR_WIDTH-1:0]      base_addr,
  input  logic [DIM_WIDTH-1:0]       fmap_width,
  input  logic [DIM_WIDTH-1:0]       fmap_height,
  output logic                       rd_en_1,
  output logic                       rd_en_2,
  output logic                       rd_en_3,
  output logic                       rd_en_4,
  output logic [ADDR_WIDTH-1:0]      rd_addr_1,
  output logic [ADDR_WIDTH-1:0]      rd_addr_2,
  output logic [ADDR_WIDTH-1:0]      rd_addr_3,
  output logic [ADDR_WIDTH-1:0]      rd_addr_4,
  input  logic [BRAM_DATA_WIDTH-1:0] rd_data_1,
  input  logic [BRAM_DATA_WIDTH-1:0] rd_data_2,
  input  logic [BRAM_DATA_WIDTH-1:0] rd_data_3,
  input  logic [BRAM_DATA_WIDTH-1:0] rd_data_4,
  output logic [BRAM_DATA_WIDTH-1:0] bram_data_1,
  output logic [BRAM_DATA_WIDTH-1:0] bram_data_2,
  output logic [BRAM_DATA_WIDTH-1:0] bram_data_3,
  output logic [BRAM_DATA_WIDTH-1:0] bram_data_4,
  output logic                       data_valid_1,
  output logic                       data_valid_2,
  output logic                       data_valid_3,
  output logic                       data_valid_4,
  output logic                       busy,
  output logic                       done
);

  localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(RD_LATENCY - 1);

  fetch_state_t          state;
  logic [DIM_WIDTH-1:0]  cfg_w, cfg_h, wc, wr;
  logic [ADDR_WIDTH-1:0] top_addr, row_addr;
  logic [CNT_W-1:0]      drain_cnt;
  logic [3:0]            rd_en, data_valid;
  logic [ADDR_WIDTH-1:0] rd_addr [4];

  logic [DIM_WIDTH-1:0]  src_w, src_h, n_cols, n_rows, nxt_wc, nxt_wr;
  logic [ADDR_WIDTH-1:0] src_w_a, nxt_top, nxt_row;
  logic [ADDR_WIDTH-1:0] elem_addr [4];
  logic                  map_empty, have_next, load, right_ok, bottom_ok;
  logic [3:0]            nxt_en;

  // While idle the window geometry comes straight from the ports so window 0 is ready at start.
  always_comb begin
    src_w   = (state == ST_IDLE) ? fmap_width  : cfg_w;
    src_h   = (state == ST_IDLE) ? fmap_height : cfg_h;
`ifdef POOL_FETCH_ODD_EDGE_EN
    n_cols  = DIM_WIDTH'(({1'b0, src_w} + 1'b1) >> 1);
    n_rows  = DIM_WIDTH'(({1'b0, src_h} + 1'b1) >> 1);
`else
    n_cols  = src_w >> 1;
    n_rows  = src_h >> 1;
`endif
    src_w_a   = ADDR_WIDTH'(src_w);
    map_empty = (n_cols == '0) || (n_rows == '0);
    have_next = 1'b0;
    nxt_wc    = '0;
    nxt_wr    = '0;
    nxt_top   = base_addr;
    nxt_row   = base_addr;
    if (state == ST_IDLE) begin
      have_next = !map_empty;
    end else if (map_empty) begin
      have_next = 1'b0;
    end else if (wc != n_cols - 1'b1) begin
      have_next = 1'b1;
      nxt_wc    = wc + 1'b1;
      nxt_wr    = wr;
      nxt_top   = top_addr + ADDR_WIDTH'(2);
      nxt_row   = row_addr;
    end else if (wr != n_rows - 1'b1) begin
      have_next = 1'b1;
      nxt_wr    = wr + 1'b1;
      nxt_row   = row_addr + (src_w_a << 1);
      nxt_top   = row_addr + (src_w_a << 1);
    end
`ifdef POOL_FETCH_ODD_EDGE_EN
    right_ok  = !(src_w[0] && (nxt_wc == n_cols - 1'b1));
    bottom_ok = !(src_h[0] && (nxt_wr == n_rows - 1'b1));
`else
    right_ok  = 1'b1;
    bottom_ok = 1'b1;
`endif
    nxt_en       = window_enables(right_ok, bottom_ok);
    elem_addr[0] = nxt_top;
    elem_addr[1] = nxt_top + 1'b1;
    elem_addr[2] = nxt_top + src_w_a;
    elem_addr[3] = nxt_top + src_w_a + 1'b1;
    load = have_next && ((state == ST_ISSUE) || ((state == ST_IDLE) && start));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cfg_w     <= '0;
      cfg_h     <= '0;
      wc        <= '0;
      wr        <= '0;
      top_addr  <= '0;
      row_addr  <= '0;
      drain_cnt <= '0;
      rd_en     <= '0;
      done      <= 1'b0;
      for (int k = 0; k < 4; k++) rd_addr[k] <= '0;
    end else begin
      done  <= 1'b0;
      rd_en <= load ? nxt_en : 4'b0000;
      if (load) begin
        wc       <= nxt_wc;
        wr       <= nxt_wr;
        top_addr <= nxt_top;
        row_addr <= nxt_row;
      end
      // Disabled elements keep their previous address so the port does not toggle needlessly.
      for (int k = 0; k < 4; k++) begin
        if (load && nxt_en[k]) rd_addr[k] <= elem_addr[k];
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            cfg_w <= fmap_width;
            cfg_h <= fmap_height;
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!have_next) begin
            if (map_empty) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state     <= ST_DRAIN;
              drain_cnt <= DRAIN_LOAD;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == '0) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  shift_reg #(
    .CLOCK_CYCLES(RD_LATENCY),
    .DATA_WIDTH  (4)
  ) u_valid_dly (
    .clk  (clk),
    .reset(reset),
    .din  (rd_en),
    .dout (data_valid)
  );

  assign busy         = (state != ST_IDLE);
  assign rd_en_1      = rd_en[0];
  assign rd_en_2      = rd_en[1];
  assign rd_en_3      = rd_en[2];
  assign rd_en_4      = rd_en[3];
  assign rd_addr_1    = rd_addr[0];
  assign rd_addr_2    = rd_addr[1];
  assign rd_addr_3    = rd_addr[2];
  assign rd_addr_4    = rd_addr[3];
  assign data_valid_1 = data_valid[0];
  assign data_valid_2 = data_valid[1];
  assign data_valid_3 = data_valid[2];
  assign data_valid_4 = data_valid[3];
  assign bram_data_1  = data_valid[0] ? rd_data_1 : '0;
  assign bram_data_2  = data_valid[1] ? rd_data_2 : '0;
  assign bram_data_3  = data_valid[2] ? rd_data_3 : '0;
  assign bram_data_4  = data_valid[3] ? rd_data_4 : '0;

endmodule
